bsg_wormhole_loopback_responder: RTL
====================================

// Module: bsg_wormhole_loopback_responder
// PURPOSE
//  Single-clock wormhole endpoint that receives a test packet flit-by-flit on a ready_and link, reassembles it,
//  and returns a response packet on the same link. The response carries the same payload with the cid fields swapped.
//  It is the responder end of the concentrator test traffic, for benches where endpoints share the router clock.
//  It is attached directly below a bsg_wormhole_concentrator client port or a router port, with no async FIFOs.
// PARAMETERS
//  flit_width_p     (none)  link flit width in bits
//  cord_width_p     5       header cord field width
//  len_width_p      (none)  header len field width; must be >= clog2(ratio)
//  cid_width_p      (none)  cid/src_cid field width
//  num_channels_p   (none)  payload channel count
//  channel_width_p  (none)  payload channel width
//  Derived: W = num_channels_p*channel_width_p
//           P = W + 2*cid_width_p + len_width_p + cord_width_p
//           R = ceil(P/flit_width_p)
// PORTS
//  clk_i        in   1                 clock
//  reset_i      in   1                 synchronous, active-high reset
//  my_cord_i    in   cord_width_p      this node's cord
//  dest_cord_i  in   cord_width_p      cord written into response header
//  my_cid_i     in   cid_width_p       this node's cid
//  link_i       in   flit_width_p+2    bsg_ready_and_link_sif {v, data, ready_and_rev}
//  link_o       out  flit_width_p+2    bsg_ready_and_link_sif
//  received_o   out  32                packets fully received, wraps at 2^32
//  error_o      out  1                 sticky header error (see CONFIGURATION)
// BEHAVIOUR
//  Packet layout, LSB first: {load[W], src_cid, cid, hdr.len, hdr.cord}, zero-padded to R*flit_width_p.
//  Flit k carries bits [k*flit_width_p +: flit_width_p].
//  FSM states:
//   RECV: link_o.ready_and_rev=1; each accepted flit (link_i.v) is written into slot cnt of the R-flit buffer; cnt++.
//         On acceptance of flit R-1: received_o++, cnt<=0, go to SEND.
//   SEND: link_o.ready_and_rev=0; link_o.v=1; link_o.data = response flit cnt.
//         Flit is consumed when link_i.ready_and_rev=1; cnt++.
//         On consumption of flit R-1: cnt<=0, go to RECV.
//  Response fields: hdr.cord=dest_cord_i, hdr.len=R-1, cid=rx.src_cid, src_cid=my_cid_i, load=rx.load[W-1:0].
//   The cord/cid inputs are sampled combinationally while in SEND.
//  The receiver ignores the rx hdr.len field; packet length is always R flits.
//  Latency: response flit 0 is valid the cycle after the last rx flit is accepted. Best case, a packet turns around in 2R cycles.
//  Half-duplex: no flit is accepted while in SEND; the upstream link stalls via ready_and_rev=0.
//  link_o.v is never deasserted mid-packet; link_o.data is held stable while v && !ready.
//  R==1: RECV->SEND->RECV each take one handshake; cnt stays 0.
//  Reset (including mid-packet): state=RECV, cnt=0, received_o=0, error_o=0, link_o.v=0.
//   Any partial packet is discarded. link_o.ready_and_rev=1 from the first cycle after reset deasserts.
//  Buffer contents are not reset; they are only read after a full R-flit fill.
// CONFIGURATION
//  BSG_WORMHOLE_LOOPBACK_RESPONDER_CHECK_EN
//   Defined: on completion of each received packet, error_o<=1 (sticky until reset) if any of these mismatch:
//    rx hdr.cord != my_cord_i, rx cid != my_cid_i, or rx hdr.len != R-1.
//    $error is emitted, not under synthesis. The response is still sent.
//   Undefined: error_o is tied 0 and no compare logic is built.
// TESTING
//  Config for all scenarios: flit 32, cord 5, len 3, cid 2, 2x32 payload -> P=76, R=3.
//  1. Send one packet (cord=my, cid=1, src_cid=2, load=64'hDEAD_BEEF_0123_4567) with ready held 1.
//     -> 3 response flits with cid=2, src_cid=1, same load, hdr.len=2; received_o=1.
//  2. Stall: hold link_i.ready_and_rev=0 for 5 cycles during response flit 1.
//     -> flit 1 held stable; no rx flits accepted; packet completes after release.
//  3. Back-to-back: stream 100 packets with incrementing load.
//     -> 100 ordered, correct responses; received_o=100; error_o=0.
//  4. Assert reset after rx flit 1 of 3, then send a full packet.
//     -> partial packet dropped; exactly one response; received_o=1.
//  5. With CHECK_EN, send cid=3 while my_cid_i=1.
//     -> error_o=1 the cycle after the last rx flit; response still sent; error_o stays 1 until reset.
//  6. received_o wrap: force count to 32'hFFFF_FFFF, receive 1 packet -> received_o=0.

Source files
------------

// File: rtl/bsg_wormhole_loopback_responder.sv
// Wormhole loopback responder: reassembles an R-flit packet, then returns it with cid fields swapped.
// Optional header checking is enabled by defining BSG_WORMHOLE_LOOPBACK_RESPONDER_CHECK_EN.
module bsg_wormhole_loopback_responder #(
    parameter int flit_width_p    = 32,
    parameter int cord_width_p    = 5,
    parameter int len_width_p     = 3,
    parameter int cid_width_p     = 2,
    parameter int num_channels_p  = 2,
    parameter int channel_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [cord_width_p-1:0]   my_cord_i,
    input  logic [cord_width_p-1:0]   dest_cord_i,
    input  logic [cid_width_p-1:0]    my_cid_i,
    input  logic [flit_width_p+1:0]   link_i,
    output logic [flit_width_p+1:0]   link_o,
    output logic [31:0]               received_o,
    output logic                      error_o
);

    localparam int W        = num_channels_p * channel_width_p;
    localparam int P        = W + 2 * cid_width_p + len_width_p + cord_width_p;
    localparam int R        = (P + flit_width_p - 1) / flit_width_p;
    localparam int BUF_W    = R * flit_width_p;
    localparam int CNT_W    = (R > 1) ? $clog2(R) : 1;
    localparam int OFS_LEN  = cord_width_p;
    localparam int OFS_CID  = OFS_LEN + len_width_p;
    localparam int OFS_SRC  = OFS_CID + cid_width_p;
    localparam int OFS_LOAD = OFS_SRC + cid_width_p;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

    typedef enum logic {S_RECV, S_SEND} state_e;

    state_e                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic [BUF_W-1:0]        r_buf;
    logic [BUF_W-1:0]        w_resp;
    logic [31:0]             r_received;
    logic                    w_in_v, w_in_rdy;
    logic [flit_width_p-1:0] w_in_data, w_out_data;
    logic                    w_accept, w_rx_done, w_v_out, w_rdy_out;
    logic                    w_unused;

    assign w_in_v    = link_i[flit_width_p+1];
    assign w_in_data = link_i[flit_width_p:1];
    assign w_in_rdy  = link_i[0];

    // Response header is built live from the cord/cid inputs while sending.
    always_comb begin
        w_resp                             = '0;
        w_resp[0 +: cord_width_p]          = dest_cord_i;
        w_resp[OFS_LEN +: len_width_p]     = len_width_p'(R - 1);
        w_resp[OFS_CID +: cid_width_p]     = r_buf[OFS_SRC +: cid_width_p];
        w_resp[OFS_SRC +: cid_width_p]     = my_cid_i;
        w_resp[OFS_LOAD +: W]              = r_buf[OFS_LOAD +: W];
    end

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_rx_done    = 1'b0;
        w_v_out      = 1'b0;
        w_rdy_out    = 1'b0;
        w_out_data   = '0;
        case (r_state)
            S_RECV: begin
                w_rdy_out = 1'b1;
                w_accept  = w_in_v;
                if (w_accept) begin
                    if (r_cnt == LAST) begin
                        w_rx_done    = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_SEND;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_SEND: begin
                w_v_out    = 1'b1;
                w_out_data = w_resp[r_cnt*flit_width_p +: flit_width_p];
                if (w_in_rdy) begin
                    if (r_cnt == LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = S_RECV;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = S_RECV;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_RECV;
            r_cnt      <= '0;
            r_received <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_rx_done)
                r_received <= r_received + 32'd1;
        end
    end

    // NOTE: the packet buffer is deliberately not reset; it is only read after a full fill.
    always_ff @(posedge clk_i) begin
        if (w_accept)
            r_buf[r_cnt*flit_width_p +: flit_width_p] <= w_in_data;
    end

    assign link_o     = {w_v_out, w_out_data, w_rdy_out};
    assign received_o = r_received;
    // Header fields and padding of the rx buffer are intentionally not all consumed.
    assign w_unused   = ^{my_cord_i, r_buf};

`ifdef BSG_WORMHOLE_LOOPBACK_RESPONDER_CHECK_EN
    logic [BUF_W-1:0] w_rx_pkt;
    logic             w_hdr_bad;
    logic             r_error;

    // Header check must see the flit being accepted this cycle.
    always_comb begin
        w_rx_pkt = r_buf;
        w_rx_pkt[r_cnt*flit_width_p +: flit_width_p] = w_in_data;
        w_hdr_bad = (w_rx_pkt[0 +: cord_width_p] != my_cord_i)
                 || (w_rx_pkt[OFS_CID +: cid_width_p] != my_cid_i)
                 || (w_rx_pkt[OFS_LEN +: len_width_p] != len_width_p'(R - 1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_error <= 1'b0;
        else if (w_rx_done && w_hdr_bad)
            r_error <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_rx_done && w_hdr_bad)
            $error("bsg_wormhole_loopback_responder: header mismatch in received packet");
    end
`endif

    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

endmodule
